// File: rtl/gated_bus_ctrl.sv
// Gated N-source datapath bus with bus keeper and contention monitor.
// Define BUS_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module gated_bus_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]         gate,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           BUS_out,
  output logic                       bus_valid,
  output logic [NUM_SRC-1:0]         grant,
  output logic [WIDTH-1:0]           hold_q,
  output logic                       conflict,
  output logic                       conflict_sticky,
  output logic [CNT_W-1:0]           conflict_cnt
);

  localparam int unsigned PtrW = $clog2(NUM_SRC);

  logic [WIDTH-1:0] src_arr [NUM_SRC];
  logic [PtrW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             found;

  logic [WIDTH-1:0] hold_d;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_arr[i] = src_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef BUS_RR_EN
  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] rr_ptr_d;
  int unsigned     cand;

  // Search starts at rr_ptr_q and wraps modulo NUM_SRC.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      if (!found && gate[PtrW'(cand)]) begin
        found   = 1'b1;
        sel_idx = PtrW'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bus_valid) begin
      rr_ptr_d = (sel_idx == PtrW'(NUM_SRC - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!found && gate[i]) begin
        found   = 1'b1;
        sel_idx = PtrW'(i);
      end
    end
  end
`endif

  assign bus_valid = |gate;
  assign sel_data  = src_arr[sel_idx];
  assign BUS_out   = bus_valid ? sel_data : hold_q;

  always_comb begin
    grant = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      grant[i] = bus_valid && (sel_idx == PtrW'(i));
    end
  end

  // Contention = a second asserted gate after one has already been seen.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    conflict = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      conflict = conflict | (seen & gate[i]);
      seen     = seen | gate[i];
    end
  end

  always_comb begin
    hold_d   = bus_valid ? sel_data : hold_q;
    sticky_d = conflict_sticky;
    cnt_d    = conflict_cnt;
    if (conflict) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end
    // A same-cycle event survives the clear and is counted as the first one.
    if (clr_err) begin
      cnt_d = conflict ? CNT_W'(1) : '0;
    end else if (conflict && (conflict_cnt != '1)) begin
      cnt_d = conflict_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_q          <= '0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else begin
      hold_q          <= hold_d;
      conflict_sticky <= sticky_d;
      conflict_cnt    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gated_bus_ctrl.sv
// Self-checking bench for gated_bus_ctrl: per-cycle model comparison plus literal checkpoints.
// Honours BUS_RR_EN the same way as the design.
module tb_gated_bus_ctrl;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 8;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   gate;
  logic           clr_err;
  logic [W-1:0]   BUS_out;
  logic           bus_valid;
  logic [N-1:0]   grant;
  logic [W-1:0]   hold_q;
  logic           conflict;
  logic           conflict_sticky;
  logic [CW-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state
  int  m_hold   = 0;
  int  m_sticky = 0;
  int  m_cnt    = 0;
  int  m_ptr    = 0;
  bit  model_ok = 1'b0;

  gated_bus_ctrl #(.WIDTH(W), .NUM_SRC(N), .CNT_W(CW)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .src_data        (src_data),
    .gate            (gate),
    .clr_err         (clr_err),
    .BUS_out         (BUS_out),
    .bus_valid       (bus_valid),
    .grant           (grant),
    .hold_q          (hold_q),
    .conflict        (conflict),
    .conflict_sticky (conflict_sticky),
    .conflict_cnt    (conflict_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int src_of(input int i);
    return int'(src_data[i*W +: W]);
  endfunction

  // Winning source index, or -1 when idle.
  function automatic int winner(input logic [N-1:0] g, input int ptr);
    int start;
`ifdef BUS_RR_EN
    start = ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (g[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge Clk) begin
    int w;
    int c;
    if (Reset) begin
      m_hold = 0; m_sticky = 0; m_cnt = 0; m_ptr = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      w = winner(gate, m_ptr);
      c = ($countones(gate) >= 2) ? 1 : 0;
      if (w >= 0) begin
        m_hold = src_of(w);
        m_ptr  = (w + 1) % N;
      end
      if (c == 1) m_sticky = 1;
      else if (clr_err) m_sticky = 0;
      if (clr_err) m_cnt = c;
      else if (c == 1 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge Clk) begin
    int w;
    logic [N-1:0] eg;
    if (model_ok) begin
      w  = winner(gate, m_ptr);
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("m_bus",    32'(BUS_out),   (w >= 0) ? src_of(w) : m_hold);
      chk("m_valid",  32'(bus_valid), 32'(gate != '0));
      chk("m_grant",  32'(grant),     32'(eg));
      chk("m_confl",  32'(conflict),  32'($countones(gate) >= 2));
      chk("m_hold",   32'(hold_q),    m_hold);
      chk("m_sticky", 32'(conflict_sticky), m_sticky);
      chk("m_cnt",    32'(conflict_cnt), m_cnt);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [W-1:0] v);
    src_data[i*W +: W] = v;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
`ifdef BUS_RR_EN
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    Reset = 1'b1; gate = '0; clr_err = 1'b0; src_data = '0;

    // 1: reset state
    do_reset();
    @(negedge Clk);
    chk("rst_bus",    32'(BUS_out), 32'h0);
    chk("rst_valid",  32'(bus_valid), 32'h0);
    chk("rst_grant",  32'(grant), 32'h0);
    chk("rst_confl",  32'(conflict), 32'h0);
    chk("rst_cnt",    32'(conflict_cnt), 32'h0);

    // 2: single source and keeper
    tick();
    set_src(1, 16'h1234); gate = 4'b0010;
    @(negedge Clk);
    chk("s1_bus",   32'(BUS_out), 32'h1234);
    chk("s1_grant", 32'(grant), 32'b0010);
    tick();
    gate = '0;
    @(negedge Clk);
    chk("keep_bus",  32'(BUS_out), 32'h1234);
    chk("keep_hold", 32'(hold_q), 32'h1234);
    tick();
    set_src(1, 16'hFFFF);
    @(negedge Clk);
    chk("keep_bus2", 32'(BUS_out), 32'h1234);

    // 3: two-way contention
    tick();
    do_reset();
    set_src(0, 16'hAAAA); set_src(2, 16'h5555); gate = 4'b0101;
    @(negedge Clk);
    chk("c_bus",   32'(BUS_out), 32'hAAAA);
    chk("c_grant", 32'(grant), 32'b0001);
    chk("c_confl", 32'(conflict), 32'h1);
    tick();
    gate = '0;
    @(negedge Clk);
    chk("c_sticky", 32'(conflict_sticky), 32'h1);
    chk("c_cnt",    32'(conflict_cnt), 32'h1);
    chk("c_hold",   32'(hold_q), 32'hAAAA);

    // 4: saturation and clear interplay
    tick();
    gate = 4'b0011;
    for (int i = 0; i < 300; i++) tick();
    gate = '0;
    @(negedge Clk);
    chk("sat_cnt", 32'(conflict_cnt), 32'd255);
    tick();
    clr_err = 1'b1; gate = 4'b0001;
    tick();
    @(negedge Clk);
    chk("clr_cnt",    32'(conflict_cnt), 32'h0);
    chk("clr_sticky", 32'(conflict_sticky), 32'h0);
    tick();
    gate = 4'b0011;
    tick();
    clr_err = 1'b0; gate = '0;
    @(negedge Clk);
    chk("clrc_cnt",    32'(conflict_cnt), 32'h1);
    chk("clrc_sticky", 32'(conflict_sticky), 32'h1);

    // 5: all gates for five cycles after reset
    tick();
    do_reset();
    gate = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("all_grant%0d", i), 32'(grant), 32'(rr_exp[i]));
      tick();
    end
    gate = '0;
    @(negedge Clk);
    chk("all_cnt", 32'(conflict_cnt), 32'd5);

    // 6: reset in the middle of contention
    tick();
    do_reset();
    set_src(1, 16'h00C3); set_src(2, 16'h00C3); gate = 4'b0110;
    for (int i = 0; i < 7; i++) tick();
    @(negedge Clk);
    chk("pre_cnt",  32'(conflict_cnt), 32'd7);
    chk("pre_hold", 32'(hold_q), 32'h00C3);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0; gate = '0;
    @(negedge Clk);
    chk("mid_cnt",    32'(conflict_cnt), 32'h0);
    chk("mid_sticky", 32'(conflict_sticky), 32'h0);
    chk("mid_hold",   32'(hold_q), 32'h0);
    tick();
    gate = 4'b1111;
    @(negedge Clk);
    chk("mid_grant", 32'(grant), 32'b0001);
    tick();
    gate = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
